// File: rtl/rename_unit_2w_if.sv
// ============================================================================
// Module      : rename_unit_2w_if
// Description : Decode/dispatch/retire bundle for the two-wide rename stage.
//               Readiness signals exist only when RENAME_BUSY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rename_unit_2w_if #(
    parameter int ARCH_REGS = 32,
    parameter int PHYS_REGS = 64
);
    localparam int AW = $clog2(ARCH_REGS);
    localparam int PW = $clog2(PHYS_REGS);

    logic [1:0]      in_valid;
    logic            in_ready;
    logic [2*AW-1:0] in_rs1;
    logic [2*AW-1:0] in_rs2;
    logic [2*AW-1:0] in_rd;
    logic [1:0]      in_has_rd;
    logic [1:0]      out_valid;
    logic            out_ready;
    logic [2*PW-1:0] out_ps1;
    logic [2*PW-1:0] out_ps2;
    logic [2*PW-1:0] out_pd;
    logic [2*PW-1:0] out_old_pd;
    logic [1:0]      ret_valid;
    logic [2*PW-1:0] ret_old_pd;
    logic [PW:0]     fl_count;
    logic            err;
`ifdef RENAME_BUSY_EN
    logic            wb_valid;
    logic [PW-1:0]   wb_pd;
    logic [1:0]      out_ps1_rdy;
    logic [1:0]      out_ps2_rdy;
`endif

    modport master (
        output in_valid, in_rs1, in_rs2, in_rd, in_has_rd, out_ready,
        output ret_valid, ret_old_pd,
`ifdef RENAME_BUSY_EN
        output wb_valid, wb_pd,
        input  out_ps1_rdy, out_ps2_rdy,
`endif
        input  in_ready, out_valid, out_ps1, out_ps2, out_pd, out_old_pd,
        input  fl_count, err
    );

    modport slave (
        input  in_valid, in_rs1, in_rs2, in_rd, in_has_rd, out_ready,
        input  ret_valid, ret_old_pd,
`ifdef RENAME_BUSY_EN
        input  wb_valid, wb_pd,
        output out_ps1_rdy, out_ps2_rdy,
`endif
        output in_ready, out_valid, out_ps1, out_ps2, out_pd, out_old_pd,
        output fl_count, err
    );
endinterface

`default_nettype wire

// File: rtl/rename_unit_2w.sv
// ============================================================================
// Module      : rename_unit_2w
// Description : Two-wide register rename: RAT, circular free list, intra-group
//               bypass, retire recycling. Optional busy table: RENAME_BUSY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rename_unit_2w #(
    parameter int ARCH_REGS = 32,
    parameter int PHYS_REGS = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    rename_unit_2w_if.slave  bus
);
    localparam int AW       = $clog2(ARCH_REGS);
    localparam int PW       = $clog2(PHYS_REGS);
    localparam int FL_DEPTH = PHYS_REGS - ARCH_REGS;
    localparam int FW       = $clog2(FL_DEPTH);

    logic [PW-1:0] r_rat [ARCH_REGS];
    logic [PW-1:0] r_fl  [FL_DEPTH];
    logic [FW-1:0] r_head;
    logic [FW-1:0] r_tail;
    logic [PW:0]   r_count;
    logic          r_err;
    logic [1:0]    r_out_valid;
    logic [PW-1:0] r_ps1 [2];
    logic [PW-1:0] r_ps2 [2];
    logic [PW-1:0] r_pd  [2];
    logic [PW-1:0] r_old [2];

    logic [AW-1:0] w_rs1 [2];
    logic [AW-1:0] w_rs2 [2];
    logic [AW-1:0] w_rd  [2];
    logic [PW-1:0] w_ret [2];
    logic [PW-1:0] w_ps1 [2];
    logic [PW-1:0] w_ps2 [2];
    logic [PW-1:0] w_pd  [2];
    logic [PW-1:0] w_old [2];
    logic [1:0]    w_alloc;
    logic [1:0]    w_byp1;
    logic [1:0]    w_byp2;
    logic [1:0]    w_push_req;
    logic [1:0]    w_push;
    logic [1:0]    w_nalloc;
    logic [1:0]    w_npush;
    logic [FW-1:0] w_h1;
    logic [FW-1:0] w_t1;
    logic [PW:0]   w_avail;
    logic [PW:0]   w_count_next;
    logic          w_out_free;
    logic          w_in_ready;
    logic          w_accept;
    logic          w_overflow;

    function automatic logic [FW-1:0] ptr_add(input logic [FW-1:0] p, input logic [1:0] n);
        logic [FW+1:0] s;
        s = {2'b00, p} + {{FW{1'b0}}, n};
        if (s >= (FW+2)'(FL_DEPTH)) s = s - (FW+2)'(FL_DEPTH);
        return s[FW-1:0];
    endfunction

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            w_rs1[s] = bus.in_rs1[s*AW +: AW];
            w_rs2[s] = bus.in_rs2[s*AW +: AW];
            w_rd[s]  = bus.in_rd[s*AW +: AW];
            w_ret[s] = bus.ret_old_pd[s*PW +: PW];
            w_alloc[s]    = bus.in_valid[s] & bus.in_has_rd[s] & (w_rd[s] != '0);
            w_push_req[s] = bus.ret_valid[s] & (w_ret[s] != '0);
        end

        w_out_free = (r_out_valid == 2'b00) | bus.out_ready;
        w_in_ready = w_out_free & (r_count >= (PW+1)'(2));
        w_accept   = (|bus.in_valid) & w_in_ready;

        // Slot1 draws the entry after slot0's only when slot0 actually consumed one
        w_h1     = ptr_add(r_head, 2'd1);
        w_pd[0]  = w_alloc[0] ? r_fl[r_head] : '0;
        w_pd[1]  = w_alloc[1] ? (w_alloc[0] ? r_fl[w_h1] : r_fl[r_head]) : '0;

        w_byp1[0] = 1'b0;
        w_byp2[0] = 1'b0;
        w_byp1[1] = w_alloc[0] & (w_rs1[1] == w_rd[0]);
        w_byp2[1] = w_alloc[0] & (w_rs2[1] == w_rd[0]);
        for (int s = 0; s < 2; s++) begin
            w_ps1[s] = (w_rs1[s] == '0) ? '0 : (w_byp1[s] ? w_pd[0] : r_rat[w_rs1[s]]);
            w_ps2[s] = (w_rs2[s] == '0) ? '0 : (w_byp2[s] ? w_pd[0] : r_rat[w_rs2[s]]);
        end

        w_old[0] = w_alloc[0] ? r_rat[w_rd[0]] : '0;
        w_old[1] = '0;
        if (w_alloc[1]) w_old[1] = (w_alloc[0] && (w_rd[1] == w_rd[0])) ? w_pd[0] : r_rat[w_rd[1]];

        w_nalloc = w_accept ? ({1'b0, w_alloc[0]} + {1'b0, w_alloc[1]}) : 2'd0;

        // Allocation frees space before pushes are judged against the capacity
        w_avail    = r_count - {{(PW-1){1'b0}}, w_nalloc};
        w_push[0]  = w_push_req[0] & (w_avail < (PW+1)'(FL_DEPTH));
        w_push[1]  = w_push_req[1] & ((w_avail + {{PW{1'b0}}, w_push[0]}) < (PW+1)'(FL_DEPTH));
        w_overflow = (w_push_req[0] & ~w_push[0]) | (w_push_req[1] & ~w_push[1]);
        w_npush    = {1'b0, w_push[0]} + {1'b0, w_push[1]};
        w_t1       = w_push[0] ? ptr_add(r_tail, 2'd1) : r_tail;
        w_count_next = w_avail + {{(PW-1){1'b0}}, w_npush};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ARCH_REGS; i++) r_rat[i] <= PW'(i);
            for (int i = 0; i < FL_DEPTH; i++)  r_fl[i]  <= PW'(ARCH_REGS + i);
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= (PW+1)'(FL_DEPTH);
            r_err       <= 1'b0;
            r_out_valid <= 2'b00;
            for (int s = 0; s < 2; s++) begin
                r_ps1[s] <= '0;
                r_ps2[s] <= '0;
                r_pd[s]  <= '0;
                r_old[s] <= '0;
            end
        end else begin
            // Slot1 written last so it wins when both slots target the same rd
            if (w_accept && w_alloc[0]) r_rat[w_rd[0]] <= w_pd[0];
            if (w_accept && w_alloc[1]) r_rat[w_rd[1]] <= w_pd[1];
            if (w_push[0]) r_fl[r_tail] <= w_ret[0];
            if (w_push[1]) r_fl[w_t1]   <= w_ret[1];
            r_head  <= ptr_add(r_head, w_nalloc);
            r_tail  <= ptr_add(r_tail, w_npush);
            r_count <= w_count_next;
            if (w_overflow) r_err <= 1'b1;
            if (w_out_free) begin
                r_out_valid <= w_accept ? bus.in_valid : 2'b00;
                if (w_accept) begin
                    for (int s = 0; s < 2; s++) begin
                        r_ps1[s] <= w_ps1[s];
                        r_ps2[s] <= w_ps2[s];
                        r_pd[s]  <= w_pd[s];
                        r_old[s] <= w_old[s];
                    end
                end
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_ps1    = {r_ps1[1], r_ps1[0]};
    assign bus.out_ps2    = {r_ps2[1], r_ps2[0]};
    assign bus.out_pd     = {r_pd[1], r_pd[0]};
    assign bus.out_old_pd = {r_old[1], r_old[0]};
    assign bus.fl_count   = r_count;
    assign bus.err        = r_err;

`ifdef RENAME_BUSY_EN
    logic [PHYS_REGS-1:0] r_busy;
    logic [1:0]           r_rdy1;
    logic [1:0]           r_rdy2;
    logic [1:0]           w_rdy1;
    logic [1:0]           w_rdy2;

    // A bypassed source names a register allocated in this very group
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            w_rdy1[s] = ~w_byp1[s] & (~r_busy[w_ps1[s]] | (bus.wb_valid & (bus.wb_pd == w_ps1[s])));
            w_rdy2[s] = ~w_byp2[s] & (~r_busy[w_ps2[s]] | (bus.wb_valid & (bus.wb_pd == w_ps2[s])));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy <= '0;
            r_rdy1 <= 2'b00;
            r_rdy2 <= 2'b00;
        end else begin
            if (bus.wb_valid && (bus.wb_pd != '0)) r_busy[bus.wb_pd] <= 1'b0;
            if (w_accept && w_alloc[0]) r_busy[w_pd[0]] <= 1'b1;
            if (w_accept && w_alloc[1]) r_busy[w_pd[1]] <= 1'b1;
            if (w_out_free && w_accept) begin
                r_rdy1 <= w_rdy1;
                r_rdy2 <= w_rdy2;
            end
        end
    end

    assign bus.out_ps1_rdy = r_rdy1;
    assign bus.out_ps2_rdy = r_rdy2;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rename_unit_2w.sv
// ============================================================================
// Module      : tb_rename_unit_2w
// Description : Directed self-checking bench for rename_unit_2w.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rename_unit_2w;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    rename_unit_2w_if bus ();

    rename_unit_2w dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic grp(input logic [1:0] v,
                       input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad, input logic ah,
                       input logic [4:0] b1, input logic [4:0] b2, input logic [4:0] bd, input logic bh);
        bus.in_valid  = v;
        bus.in_rs1    = {b1, a1};
        bus.in_rs2    = {b2, a2};
        bus.in_rd     = {bd, ad};
        bus.in_has_rd = {bh, ah};
    endtask

    task automatic idle();
        grp(2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        bus.ret_valid = 2'b00;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        idle();
        bus.out_ready  = 1'b1;
        bus.ret_valid  = 2'b00;
        bus.ret_old_pd = '0;
`ifdef RENAME_BUSY_EN
        bus.wb_valid = 1'b0;
        bus.wb_pd    = '0;
`endif
        tick();
        tick();
        rst_n = 1'b1;

        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_fl_count", bus.fl_count, 32);
        chk("rst_err", bus.err, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_pd", bus.out_pd, 0);
        chk("rst_out_old_pd", bus.out_old_pd, 0);

        // add x5<-x1,x2 ; add x6<-x5,x3
        grp(2'b11, 5'd1, 5'd2, 5'd5, 1'b1, 5'd5, 5'd3, 5'd6, 1'b1);
        tick();
        chk("a_out_valid", bus.out_valid, 3);
        chk("a_ps1_0", bus.out_ps1[5:0], 1);
        chk("a_ps2_0", bus.out_ps2[5:0], 2);
        chk("a_pd0", bus.out_pd[5:0], 32);
        chk("a_old0", bus.out_old_pd[5:0], 5);
        chk("a_ps1_1_bypass", bus.out_ps1[11:6], 32);
        chk("a_ps2_1", bus.out_ps2[11:6], 3);
        chk("a_pd1", bus.out_pd[11:6], 33);
        chk("a_old1", bus.out_old_pd[11:6], 6);
        chk("a_fl_count", bus.fl_count, 30);
`ifdef RENAME_BUSY_EN
        chk("a_ps1_rdy", bus.out_ps1_rdy, 2'b01);
`endif
        idle();
        tick();
        chk("a_drain_valid", bus.out_valid, 0);
`ifdef RENAME_BUSY_EN
        grp(2'b01, 5'd5, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        chk("busy_ps1", bus.out_ps1[5:0], 32);
        chk("busy_rdy0", bus.out_ps1_rdy[0], 0);
        bus.wb_valid = 1'b1;
        bus.wb_pd    = 6'd32;
        tick();
        bus.wb_valid = 1'b0;
        chk("wb_bypass_rdy0", bus.out_ps1_rdy[0], 1);
        idle();
`endif

        // both slots write x7
        do_reset();
        grp(2'b11, 5'd1, 5'd0, 5'd7, 1'b1, 5'd7, 5'd0, 5'd7, 1'b1);
        tick();
        chk("b_pd0", bus.out_pd[5:0], 32);
        chk("b_old0", bus.out_old_pd[5:0], 7);
        chk("b_pd1", bus.out_pd[11:6], 33);
        chk("b_old1", bus.out_old_pd[11:6], 32);
        chk("b_ps1_1", bus.out_ps1[11:6], 32);
        grp(2'b01, 5'd7, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        chk("b_read_x7", bus.out_ps1[5:0], 33);
        chk("b_noalloc_pd", bus.out_pd[5:0], 0);
        chk("b_noalloc_old", bus.out_old_pd[5:0], 0);
        chk("b_fl_count", bus.fl_count, 30);

        // rd=x0 both slots, then drain to one entry
        do_reset();
        grp(2'b11, 5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
        tick();
        chk("c_x0_valid", bus.out_valid, 3);
        chk("c_x0_pd", bus.out_pd, 0);
        chk("c_x0_old", bus.out_old_pd, 0);
        chk("c_x0_fl", bus.fl_count, 32);
        grp(2'b01, 5'd0, 5'd0, 5'd9, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        chk("c_head_kept", bus.out_pd[5:0], 32);
        chk("c_fl31", bus.fl_count, 31);
        for (int i = 0; i < 15; i++) begin
            grp(2'b11, 5'd0, 5'd0, 5'd10, 1'b1, 5'd0, 5'd0, 5'd11, 1'b1);
            tick();
        end
        chk("c_last_pd", bus.out_pd, {6'd62, 6'd61});
        chk("c_fl1", bus.fl_count, 1);
        chk("c_stall_ready", bus.in_ready, 0);
        grp(2'b01, 5'd0, 5'd0, 5'd12, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        chk("c_stall_valid", bus.out_valid, 0);
        chk("c_stall_fl", bus.fl_count, 1);
        bus.ret_valid  = 2'b01;
        bus.ret_old_pd = {6'd0, 6'd5};
        tick();
        bus.ret_valid = 2'b00;
        chk("c_ret_fl", bus.fl_count, 2);
        chk("c_ret_ready", bus.in_ready, 1);
        grp(2'b11, 5'd0, 5'd0, 5'd12, 1'b1, 5'd0, 5'd0, 5'd13, 1'b1);
        bus.ret_valid  = 2'b11;
        bus.ret_old_pd = {6'd0, 6'd40};
        tick();
        bus.ret_valid = 2'b00;
        idle();
        chk("c_wrap_pd0", bus.out_pd[5:0], 63);
        chk("c_wrap_pd1", bus.out_pd[11:6], 5);
        chk("c_wrap_old", bus.out_old_pd, {6'd13, 6'd12});
        chk("c_acc_ret_fl", bus.fl_count, 1);
        chk("c_p0_drop_err", bus.err, 0);

        // backpressure hold
        do_reset();
        bus.out_ready = 1'b0;
        grp(2'b11, 5'd1, 5'd0, 5'd5, 1'b1, 5'd0, 5'd0, 5'd6, 1'b1);
        tick();
        chk("d_first_pd", bus.out_pd, {6'd33, 6'd32});
        grp(2'b11, 5'd5, 5'd0, 5'd8, 1'b1, 5'd0, 5'd0, 5'd9, 1'b1);
        chk("d_hold_ready", bus.in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("d_hold_pd", bus.out_pd, {6'd33, 6'd32});
            chk("d_hold_valid", bus.out_valid, 3);
            chk("d_hold_fl", bus.fl_count, 30);
            chk("d_hold_err", bus.err, 0);
        end
        bus.out_ready = 1'b1;
        tick();
        idle();
        chk("d_next_pd", bus.out_pd, {6'd35, 6'd34});
        chk("d_next_old0", bus.out_old_pd[5:0], 8);
        chk("d_next_ps1", bus.out_ps1[5:0], 32);
        chk("d_next_fl", bus.fl_count, 28);

        // retire into a full list
        do_reset();
        bus.ret_valid  = 2'b01;
        bus.ret_old_pd = {6'd0, 6'd40};
        tick();
        bus.ret_valid = 2'b00;
        chk("e_overflow_err", bus.err, 1);
        chk("e_overflow_fl", bus.fl_count, 32);
        tick();
        chk("e_err_sticky", bus.err, 1);
        do_reset();
        tick();
        chk("e_err_cleared", bus.err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
